// File: rtl/msrv32_store_unit.sv
// Store unit: formats rs2 into an aligned word write with byte-lane mask and runs the data-memory write handshake.
// Define MSRV32_STORE_MISALIGN_CHK_EN to drop misaligned half/word stores instead of issuing them.
//
// state | meaning
// IDLE  | no write outstanding, dmwr_req low
// BUSY  | write issued, waiting for ahb_ready_in (or timeout)
module msrv32_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        store_req_in,
  input  logic [1:0]  store_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        store_stall_out,
  output logic        misaligned_store_out,
  output logic        timeout_err_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t            state, state_nxt;
  logic [31:0]       addr_q, addr_nxt, data_q, data_nxt;
  logic [3:0]        mask_q, mask_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              mis_q, mis_nxt, to_q, to_nxt;
  logic [31:0]       fmt_data;
  logic [3:0]        fmt_mask;
  logic              misaligned;
  logic              take;

  always_comb begin
    fmt_data = rs2_in;
    fmt_mask = 4'b1111;
    case (store_size_in)
      2'b00: begin
        fmt_data = {4{rs2_in[7:0]}};
        fmt_mask = 4'b0001 << iadder_in[1:0];
      end
      2'b01: begin
        fmt_data = {2{rs2_in[15:0]}};
        fmt_mask = iadder_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_data = rs2_in;
        fmt_mask = 4'b1111;
      end
    endcase
  end

`ifdef MSRV32_STORE_MISALIGN_CHK_EN
  assign misaligned = ((store_size_in == 2'b01) && iadder_in[0]) ||
                      (store_size_in[1] && (iadder_in[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    mask_nxt  = mask_q;
    cnt_nxt   = cnt_q;
    mis_nxt   = 1'b0;
    to_nxt    = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (store_req_in) begin
          if (misaligned) mis_nxt = 1'b1;
          else            take    = 1'b1;
        end
      end
      BUSY: begin
        if (ahb_ready_in) begin
          state_nxt = IDLE;
          if (store_req_in) begin
            if (misaligned) mis_nxt = 1'b1;
            else            take    = 1'b1;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Acceptance is identical from IDLE and from a completing BUSY cycle
    if (take) begin
      state_nxt = BUSY;
      addr_nxt  = {iadder_in[31:2], 2'b00};
      data_nxt  = fmt_data;
      mask_nxt  = fmt_mask;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      mis_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      mask_q <= mask_nxt;
      cnt_q  <= cnt_nxt;
      mis_q  <= mis_nxt;
      to_q   <= to_nxt;
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = addr_q;
  assign ms_riscv32_mp_dmdata_out    = data_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmwr_req_out  = (state == BUSY);
  assign ahb_htrans_out              = (state == BUSY) ? 2'b10 : 2'b00;
  assign store_stall_out             = (state == BUSY) && !ahb_ready_in;
  assign misaligned_store_out        = mis_q;
  assign timeout_err_out             = to_q;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Self-checking bench for msrv32_store_unit (TIMEOUT_CYCLES=4); follows MSRV32_STORE_MISALIGN_CHK_EN if defined.
module tb_msrv32_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        store_req = 1'b0;
  logic [1:0]  store_size = 2'b00;
  logic [31:0] iadder = '0;
  logic [31:0] rs2 = '0;
  logic        ready = 1'b1;
  logic [31:0] dm_addr, dm_data;
  logic [3:0]  dm_mask;
  logic        dm_req, stall, mis, to_err;
  logic [1:0]  htrans;

  int n_pass = 0;
  int n_total = 0;

`ifdef MSRV32_STORE_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // expected registered contents: last accepted store
  logic [31:0] e_addr = '0, e_data = '0;
  logic [3:0]  e_mask = '0;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  logic        m_mis;
  logic [73:0] want;
  wire  [73:0] obs = {dm_addr, dm_data, dm_mask, dm_req, htrans, stall, mis, to_err};

  msrv32_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .ms_riscv32_mp_clk_in       (clk),
    .ms_riscv32_mp_rst_in       (rst),
    .store_req_in               (store_req),
    .store_size_in              (store_size),
    .iadder_in                  (iadder),
    .rs2_in                     (rs2),
    .ahb_ready_in               (ready),
    .ms_riscv32_mp_dmaddr_out   (dm_addr),
    .ms_riscv32_mp_dmdata_out   (dm_data),
    .ms_riscv32_mp_dmwr_mask_out(dm_mask),
    .ms_riscv32_mp_dmwr_req_out (dm_req),
    .ahb_htrans_out             (htrans),
    .store_stall_out            (stall),
    .misaligned_store_out       (mis),
    .timeout_err_out            (to_err)
  );

  always #5 clk = ~clk;

  // Reference: bytes replicated across the word by multiplication, lane from byte offset
  function automatic void model(input logic [1:0] sz, input logic [31:0] rs, input logic [31:0] a,
                                output logic [31:0] d, output logic [3:0] m, output logic bad);
    int nbytes, off;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off    = int'(a % 32'd4);
    if (nbytes == 1) begin
      d = 32'(rs[7:0]) * 32'h0101_0101;
      m = 4'(1 << off);
    end else if (nbytes == 2) begin
      d = 32'(rs[15:0]) * 32'h0001_0001;
      m = (off >= 2) ? 4'hC : 4'h3;
    end else begin
      d = rs;
      m = 4'hF;
    end
    bad = CHK && ((off % nbytes) != 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [1:0] sz, input logic [31:0] rs,
                       input logic [31:0] a, input logic rdy);
    store_req = req; store_size = sz; rs2 = rs; iadder = a; ready = rdy;
    model(sz, rs, a, m_data, m_mask, m_mis);
  endtask

  task automatic accept_model();
    if (!m_mis) begin
      e_addr = iadder & ~32'd3; e_data = m_data; e_mask = m_mask;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
    repeat (3) tick();
    want = '0;
    n_total++;
    if (obs !== want) $display("FAIL reset_held: got %h want %h", obs, want); else n_pass++;
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    tick();
    n_total++;
    if (obs !== want) $display("FAIL reset_release: got %h want %h", obs, want); else n_pass++;
  endtask

  task automatic test_byte();
    drive(1'b1, 2'b00, 32'h0000_00A5, 32'h0000_1003, 1'b1);
    accept_model();
    tick();
    store_req = 1'b0;
    #1;
    want = {32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL byte_issue: got %h want %h", obs, want); else n_pass++;
    tick();
    want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL byte_done: got %h want %h", obs, want); else n_pass++;
  endtask

  task automatic test_half_wait();
    drive(1'b1, 2'b01, 32'h1234_BEEF, 32'h0000_2002, 1'b1);
    accept_model();
    tick();
    store_req = 1'b0; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      want = {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
      n_total++;
      if (obs !== want) $display("FAIL half_wait%0d: got %h want %h", i, obs, want); else n_pass++;
      tick();
    end
    ready = 1'b1;
    #1;
    want = {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL half_ready: got %h want %h", obs, want); else n_pass++;
    tick();
    want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL half_done: got %h want %h", obs, want); else n_pass++;
  endtask

  task automatic test_misaligned();
    drive(1'b1, 2'b10, 32'hCAFE_F00D, 32'h0000_3001, 1'b1);
    accept_model();
    tick();
    store_req = 1'b0;
    #1;
    want = {e_addr, e_data, e_mask, !m_mis, m_mis ? 2'b00 : 2'b10, 1'b0, m_mis, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL misalign_issue: got %h want %h", obs, want); else n_pass++;
    tick();
    want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL misalign_after: got %h want %h", obs, want); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b10, 32'h1111_2222, 32'h0000_0010, 1'b1);
    accept_model();
    tick();
    want = {32'h0000_0010, 32'h1111_2222, 4'hF, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL b2b_first: got %h want %h", obs, want); else n_pass++;
    drive(1'b1, 2'b10, 32'h3333_4444, 32'h0000_0014, 1'b1);
    accept_model();
    tick();
    store_req = 1'b0;
    #1;
    want = {32'h0000_0014, 32'h3333_4444, 4'hF, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL b2b_second: got %h want %h", obs, want); else n_pass++;
    tick();
    want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL b2b_done: got %h want %h", obs, want); else n_pass++;
  endtask

  task automatic test_timeout();
    drive(1'b1, 2'b10, 32'h5555_AAAA, 32'h0000_0040, 1'b0);
    accept_model();
    tick();
    store_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      want = {e_addr, e_data, e_mask, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
      n_total++;
      if (obs !== want) $display("FAIL timeout_busy%0d: got %h want %h", i, obs, want); else n_pass++;
      tick();
    end
    want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    n_total++;
    if (obs !== want) $display("FAIL timeout_pulse: got %h want %h", obs, want); else n_pass++;
    tick();
    want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    n_total++;
    if (obs !== want) $display("FAIL timeout_clear: got %h want %h", obs, want); else n_pass++;
    ready = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 2'b00, 32'h0000_0077, 32'h0000_0501, 1'b0);
    accept_model();
    tick();
    store_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    e_addr = '0; e_data = '0; e_mask = '0;
    want = '0;
    n_total++;
    if (obs !== want) $display("FAIL reset_busy: got %h want %h", obs, want); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if (obs !== want) $display("FAIL reset_busy_after: got %h want %h", obs, want); else n_pass++;
    ready = 1'b1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int waits;
      waits = int'($urandom_range(0, 3));
      drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
      accept_model();
      tick();
      store_req = 1'b0;
      ready = (waits == 0);
      #1;
      want = {e_addr, e_data, e_mask, !m_mis, m_mis ? 2'b00 : 2'b10,
              (!m_mis && waits != 0), m_mis, 1'b0};
      n_total++;
      if (obs !== want) $display("FAIL rand_issue%0d: got %h want %h", it, obs, want); else n_pass++;
      if (!m_mis) begin
        for (int w = 1; w < waits; w++) begin
          tick();
          n_total++;
          if (obs !== want) $display("FAIL rand_wait%0d: got %h want %h", it, obs, want); else n_pass++;
        end
        if (waits != 0) begin
          tick();
          ready = 1'b1;
        end
      end
      tick();
      want = {e_addr, e_data, e_mask, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      n_total++;
      if (obs !== want) $display("FAIL rand_done%0d: got %h want %h", it, obs, want); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_wait();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
